// File: rtl/apb_mem_bridge_pkg.sv
// Shared definitions for the APB to byte-wide memory bridge.
// Bus geometry defaults and FSM state encoding.
package apb_mem_bridge_pkg;

  localparam int BYTE           = 8;
  localparam int DEF_BUS_WIDTH  = 64;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_NBYTES     = DEF_BUS_WIDTH / BYTE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/apb_mem_bridge.sv
// APB slave that serialises each bus-wide access into byte cycles
// on an async-read, posedge-write byte memory port.
module apb_mem_bridge
  import apb_mem_bridge_pkg::*;
#(
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int NB        = BUS_WIDTH / BYTE,
  localparam int CW        = $clog2(NB)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [NB-1:0]         pstrb_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BYTE-1:0]       mem_wdata_o,
  output logic                  mem_pwrite_o,
  input  logic [BYTE-1:0]       mem_rdata_i
);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BUS_WIDTH-1:0]  wdata_q;
  logic [NB-1:0]         strb_q;
  logic                  dir_q;
  logic [BUS_WIDTH-1:0]  prdata_q;
  logic                  pready_q;
  logic                  pslverr_q;

  logic                  in_xfer;
  logic                  last;

  assign in_xfer = (state_q == XFER);
  assign last    = (cnt_q == CW'(NB - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      dir_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (psel_i && penable_i) begin
            base_q  <= paddr_i;
            wdata_q <= pwdata_i;
            strb_q  <= pstrb_i;
            dir_q   <= pwrite_i;
            cnt_q   <= '0;
            // misaligned: skip memory, answer with error
            if (paddr_i[CW-1:0] != '0) begin
              state_q   <= DONE;
              pready_q  <= 1'b1;
              pslverr_q <= 1'b1;
            end else begin
              state_q <= XFER;
            end
          end
        end
        XFER: begin
          if (!dir_q)
            prdata_q[cnt_q*BYTE +: BYTE] <= mem_rdata_i;
          if (last) begin
            state_q  <= DONE;
            cnt_q    <= '0;
            pready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr_o   = in_xfer ? base_q + ADDR_WIDTH'(cnt_q) : '0;
  assign mem_wdata_o  = wdata_q[cnt_q*BYTE +: BYTE];
  assign mem_pwrite_o = !rst_i && in_xfer && dir_q && strb_q[cnt_q];

  assign prdata_o  = prdata_q;
  assign pready_o  = pready_q;
  assign pslverr_o = pslverr_q;

endmodule

// File: tb/tb_apb_mem_bridge.sv
// Randomised scoreboard bench for apb_mem_bridge with a byte memory
// model attached to the memory port and an array-based reference.
module tb_apb_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i;
  logic [63:0] pwdata_i;
  logic [7:0]  pstrb_i;
  logic [63:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        mem_pwrite_o;
  logic [7:0]  mem_rdata_i;

  apb_mem_bridge #(.BUS_WIDTH(64), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_pwrite_o(mem_pwrite_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // memory behind the bridge: 1 KiB window, address bits above 9 ignored
  logic [7:0] tb_mem [1024] = '{default: 8'h00};
  always @(posedge clk) if (mem_pwrite_o) tb_mem[mem_addr_o[9:0]] <= mem_wdata_o;
  assign mem_rdata_i = tb_mem[mem_addr_o[9:0]];

  // reference model
  logic [7:0]  ref_mem [1024] = '{default: 8'h00};
  logic [63:0] ref_prdata = '0;

  typedef struct {
    bit          rd;
    bit          err;
    logic [63:0] data;
    int          cyc;
  } exp_t;
  exp_t q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 1024; i++)
      if (tb_mem[i] !== ref_mem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    if (bad != 0)
      $display("memory differs first at index %0h: %h vs %h", first, tb_mem[first], ref_mem[first]);
    chk(name, 64'(bad), 64'd0);
  endtask

  task automatic apb(input bit wr, input logic [31:0] a, input logic [63:0] d,
                     input logic [7:0] s, input bit drop);
    exp_t e;
    logic [31:0] ba;
    bit got;
    e.err = (a[2:0] != 3'd0);
    e.rd  = !wr;
    if (!e.err) begin
      for (int k = 0; k < 8; k++) begin
        ba = a + 32'(k);
        if (wr && s[k]) ref_mem[ba[9:0]] = d[8*k +: 8];
        if (!wr) ref_prdata[8*k +: 8] = ref_mem[ba[9:0]];
      end
    end
    e.data = ref_prdata;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = a; pwdata_i = d; pstrb_i = s;
    @(posedge clk); #1;
    penable_i = 1'b1;
    e.cyc = cyc + (e.err ? 1 : 9);
    q.push_back(e);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (drop && i == 2) begin psel_i = 1'b0; penable_i = 1'b0; end
      if (pready_o) got = 1'b1;
    end
    if (!got) begin
      void'(q.pop_back());
      chk("pready_timeout", 64'd0, 64'd1);
    end
    @(posedge clk); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  // monitor: every pready pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst_i && pready_o) begin
      if (q.size() == 0) begin
        chk("unexpected_pready", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("pslverr", 64'(pslverr_o), 64'(e.err));
        chk(e.rd ? "prdata_read" : "prdata_hold", prdata_o, e.data);
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [7:0]  s;
    rst_i = 1'b1;
    psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_pready", 64'(pready_o), 64'd0);
    chk("rst_pslverr", 64'(pslverr_o), 64'd0);
    chk("rst_prdata", prdata_o, 64'd0);
    chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_mem_pwrite", 64'(mem_pwrite_o), 64'd0);
    @(posedge clk); #1;

    apb(1, 32'h100, 64'h1122334455667788, 8'hFF, 0);
    check_mem("mem_full_write");
    apb(0, 32'h100, 64'h0, 8'h00, 0);
    apb(1, 32'h100, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0);
    check_mem("mem_partial_strb");
    apb(0, 32'h100, 64'h0, 8'h00, 0);
    apb(1, 32'h103, 64'h5555555555555555, 8'hFF, 0);
    apb(0, 32'h105, 64'h0, 8'h00, 0);
    check_mem("mem_misaligned");
    apb(1, 32'hFFFFFFF8, 64'h0123456789ABCDEF, 8'hFF, 0);
    apb(0, 32'hFFFFFFF8, 64'h0, 8'h00, 0);
    check_mem("mem_top_of_space");
    apb(1, 32'h108, 64'hDEADBEEFCAFEF00D, 8'h00, 0);
    check_mem("mem_zero_strb");
    apb(1, 32'h110, 64'h0F1E2D3C4B5A6978, 8'hA5, 1);
    apb(0, 32'h110, 64'h0, 8'h00, 0);

    // reset while byte 3 of a write is on the memory port
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1;
    paddr_i = 32'h200; pwdata_i = 64'h8877665544332211; pstrb_i = 8'hFF;
    @(posedge clk); #1 penable_i = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst_i = 1'b1; psel_i = 1'b0; penable_i = 1'b0;
    for (int k = 0; k < 3; k++) ref_mem[10'h200 + 10'(k)] = 8'h11 * 8'(k + 1);
    ref_prdata = '0;
    @(negedge clk);
    chk("rst_blocks_write", 64'(mem_pwrite_o), 64'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    chk("abort_pready", 64'(pready_o), 64'd0);
    chk("abort_prdata", prdata_o, 64'd0);
    chk("abort_mem_addr", 64'(mem_addr_o), 64'd0);
    check_mem("mem_reset_abort");
    @(posedge clk); #1;

    for (int t = 0; t < 50; t++) begin
      a = 32'($urandom_range(0, 95)) << 3;
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 7));
      s = 8'($urandom);
      if ($urandom_range(0, 7) == 0) s = 8'h00;
      apb(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, s,
          $urandom_range(0, 9) == 0);
    end
    check_mem("mem_random");

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
